ram_burst_ctrl: RTL

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

---
 rtl/ram_burst_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst controller for a single-port synchronous RAM (1-cycle read latency).
// Ports: cmd_* burst command, wr_* write beats, rd_* read beats, ram_* RAM side,
// busy/done status. Optional RAM_INIT_SWEEP_EN: zero-fill the RAM after reset.
module ram_burst_ctrl #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          done
);

  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
`ifdef RAM_INIT_SWEEP_EN
    , INIT
`endif
  } state_t;

`ifdef RAM_INIT_SWEEP_EN
  localparam state_t RST_ST = INIT;
`else
  localparam state_t RST_ST = IDLE;
`endif

  state_t        state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          done_q, done_n;
  logic          inflight;
  logic [DW-1:0] mem [2];
  logic [1:0]    sc;
  logic          rp, wp;

  logic          last, pop, pop_st, push, issue;
  logic [1:0]    occ, left;

  assign last   = (cnt == CW'(1));
  assign pop    = rd_valid && rd_ready;
  assign pop_st = pop && (sc != 2'd0);
  // a beat returning from the RAM is taken straight out when the buffer is empty
  assign push   = inflight && !(pop && (sc == 2'd0));
  assign occ    = sc + {1'b0, inflight};
  assign left   = occ - {1'b0, pop};
  assign issue  = (state == READ) && (left < 2'd2);

  assign rd_valid = (sc != 2'd0) || inflight;
  assign rd_data  = (sc != 2'd0) ? mem[rp] : ram_dout;

  always_comb begin
    state_n = state;
    addr_n  = addr;
    cnt_n   = cnt;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_n  = cmd_addr;
          cnt_n   = {1'b0, cmd_len} + CW'(1);
          state_n = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wr_valid) begin
          cnt_n = cnt - CW'(1);
          if (last) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            addr_n = addr + AW'(1);
          end
        end
      end
      READ: begin
        if (issue) begin
          cnt_n = cnt - CW'(1);
          if (last) state_n = DRAIN;
          else addr_n = addr + AW'(1);
        end
      end
      DRAIN: begin
        if (!rd_valid) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
`ifdef RAM_INIT_SWEEP_EN
      INIT: begin
        if (addr == {AW{1'b1}}) state_n = IDLE;
        else addr_n = addr + AW'(1);
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RST_ST;
      addr     <= '0;
      cnt      <= '0;
      done_q   <= 1'b0;
      inflight <= 1'b0;
      sc       <= 2'd0;
      rp       <= 1'b0;
      wp       <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      state    <= state_n;
      addr     <= addr_n;
      cnt      <= cnt_n;
      done_q   <= done_n;
      inflight <= issue;
      if (push) mem[wp] <= ram_dout;
      wp <= wp ^ push;
      rp <= rp ^ pop_st;
      sc <= sc + {1'b0, push} - {1'b0, pop_st};
    end
  end

  assign cmd_ready = rst_n && (state == IDLE);
  assign wr_ready  = (state == WRITE);
  assign busy      = rst_n && (state != IDLE);
  assign done      = done_q;
  assign ram_addr  = addr;
  assign ram_din   = (state == WRITE) ? wr_data : '0;
`ifdef RAM_INIT_SWEEP_EN
  assign ram_we = rst_n &&
    ((state == INIT) || ((state == WRITE) && wr_valid));
`else
  assign ram_we = (state == WRITE) && wr_valid;
`endif

endmodule
